// File: rtl/control_bird_if.sv
// rtl/control_bird_if.sv - control_bird signal bundle; PAUSE_EN adds the pause input
interface control_bird_if;
    logic       frame_tick;
    logic       jump;
    logic       start;
    logic [7:0] bird_y;
    logic       hit_pipe;
    logic       plot_done;
`ifdef PAUSE_EN
    logic       pause;
`endif
    logic [2:0] cur_state;
    logic       ld_y;
    logic       ld_vy;
    logic       ld_jump;
    logic       ld_init;
    logic       plot_start;
    logic       plot_erase;
    logic       game_over;
    logic [7:0] frame_count;

    modport master (
`ifdef PAUSE_EN
        input  pause,
`endif
        input  frame_tick, jump, start, bird_y, hit_pipe, plot_done,
        output cur_state, ld_y, ld_vy, ld_jump, ld_init,
        output plot_start, plot_erase, game_over, frame_count
    );

    modport slave (
`ifdef PAUSE_EN
        output pause,
`endif
        output frame_tick, jump, start, bird_y, hit_pipe, plot_done,
        input  cur_state, ld_y, ld_vy, ld_jump, ld_init,
        input  plot_start, plot_erase, game_over, frame_count
    );
endinterface

// File: rtl/control_bird.sv
// rtl/control_bird.sv - bird game FSM (erase/update/draw/check per physics frame); optional PAUSE_EN
module control_bird #(
    parameter logic [7:0]  FRAME_DIV    = 8'd1,
    parameter logic [7:0]  Y_TOP        = 8'd0,
    parameter logic [7:0]  Y_BOTTOM     = 8'd112,
    parameter logic [15:0] DRAW_TIMEOUT = 16'd4095
) (
    input  logic           clk,
    input  logic           reset,
    control_bird_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FRAME = 3'd1,
        S_ERASE      = 3'd2,
        S_UPD_Y      = 3'd3,
        S_UPD_VY     = 3'd4,
        S_DRAW       = 3'd5,
        S_CHECK      = 3'd6,
        S_GAME_OVER  = 3'd7
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  div_cnt;
    logic [7:0]  div_cnt_nxt;
    logic [15:0] to_cnt;
    logic [15:0] to_cnt_nxt;
    logic        jump_pending;
    logic        jump_pending_nxt;
    logic [7:0]  frame_count_nxt;
    logic        paused;
    logic        jump_ok;
    logic        plot_ack;
    logic        collide;

    assign bus.cur_state = state;

    // Next state, counters and the jump latch, decoded from the current state and inputs
    always_comb begin
        paused = 1'b0;
`ifdef PAUSE_EN
        paused = bus.pause && (state == S_WAIT_FRAME);
`endif
        jump_ok  = bus.jump && (state != S_IDLE) && (state != S_GAME_OVER) && !paused;
        plot_ack = bus.plot_done || (({1'b0, to_cnt} + 17'd1) >= {1'b0, DRAW_TIMEOUT});
        collide  = (bus.bird_y <= Y_TOP) || (bus.bird_y >= Y_BOTTOM) || bus.hit_pipe;

        state_nxt        = state;
        div_cnt_nxt      = div_cnt;
        frame_count_nxt  = bus.frame_count;
        jump_pending_nxt = jump_pending | jump_ok;

        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = S_WAIT_FRAME;
            end
            S_WAIT_FRAME: begin
                if (bus.frame_tick && !paused) begin
                    if (div_cnt == FRAME_DIV - 8'd1) begin
                        div_cnt_nxt = 8'd0;
                        state_nxt   = S_ERASE;
                    end else begin
                        div_cnt_nxt = div_cnt + 8'd1;
                    end
                end
            end
            S_ERASE: begin
                if (plot_ack) state_nxt = S_UPD_Y;
            end
            S_UPD_Y: begin
                state_nxt = S_UPD_VY;
            end
            S_UPD_VY: begin
                // A jump arriving while the pending one is consumed survives to the next frame
                jump_pending_nxt = jump_ok;
                state_nxt        = S_DRAW;
            end
            S_DRAW: begin
                if (plot_ack) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (collide) begin
                    state_nxt = S_GAME_OVER;
                end else begin
                    frame_count_nxt = bus.frame_count + 8'd1;
                    state_nxt       = S_WAIT_FRAME;
                end
            end
            S_GAME_OVER: begin
                if (bus.start) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        if ((state_nxt == state) && ((state == S_ERASE) || (state == S_DRAW)))
            to_cnt_nxt = to_cnt + 16'd1;
        else
            to_cnt_nxt = 16'd0;
    end

    // State and internal counters register
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            div_cnt      <= 8'd0;
            to_cnt       <= 16'd0;
            jump_pending <= 1'b0;
        end else begin
            state        <= state_nxt;
            div_cnt      <= div_cnt_nxt;
            to_cnt       <= to_cnt_nxt;
            jump_pending <= jump_pending_nxt;
        end
    end

    // Outputs registered from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ld_init     <= 1'b0;
            bus.ld_y        <= 1'b0;
            bus.ld_vy       <= 1'b0;
            bus.ld_jump     <= 1'b0;
            bus.plot_start  <= 1'b0;
            bus.plot_erase  <= 1'b0;
            bus.game_over   <= 1'b0;
            bus.frame_count <= 8'd0;
        end else begin
            bus.ld_init     <= (state_nxt == S_IDLE);
            bus.ld_y        <= (state_nxt == S_UPD_Y);
            bus.ld_vy       <= (state_nxt == S_UPD_VY) && !jump_pending_nxt;
            bus.ld_jump     <= (state_nxt == S_UPD_VY) && jump_pending_nxt;
            bus.plot_start  <= ((state_nxt == S_ERASE) || (state_nxt == S_DRAW)) && (state_nxt != state);
            bus.plot_erase  <= (state_nxt == S_ERASE) && (state != S_ERASE);
            bus.game_over   <= (state_nxt == S_GAME_OVER);
            bus.frame_count <= frame_count_nxt;
        end
    end

endmodule

// File: tb/tb_control_bird.sv
// tb/tb_control_bird.sv - randomized bench for control_bird with an in-bench game model
module tb_control_bird;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       jump;
    logic       start;
    logic [7:0] bird_y;
    logic       hit_pipe;
    logic       plot_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    control_bird_if bus0();
    control_bird_if bus1();

    assign bus0.frame_tick = frame_tick;
    assign bus0.jump       = jump;
    assign bus0.start      = start;
    assign bus0.bird_y     = bird_y;
    assign bus0.hit_pipe   = hit_pipe;
    assign bus0.plot_done  = plot_done;
    assign bus1.frame_tick = frame_tick;
    assign bus1.jump       = jump;
    assign bus1.start      = start;
    assign bus1.bird_y     = bird_y;
    assign bus1.hit_pipe   = hit_pipe;
    assign bus1.plot_done  = plot_done;

    control_bird dut0 (.clk(clk), .reset(reset), .bus(bus0));

    control_bird #(
        .FRAME_DIV(8'd3), .Y_TOP(8'd10), .Y_BOTTOM(8'd100), .DRAW_TIMEOUT(16'd16)
    ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // game model: phase numbers follow the published state codes
    int p_fd[2] = '{1, 3};
    int p_to[2] = '{4095, 16};
    int p_yt[2] = '{0, 10};
    int p_yb[2] = '{112, 100};
    int st[2], prev[2], dv[2], tc[2], fc[2];
    bit jp[2], fresh[2];
    bit model_valid = 1'b0;

    task automatic cmp(string nm, int i, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, i, $time, act, exp);
        end
    endtask

    task automatic model_step(int i);
        int  nx;
        bit  jok, ack, col;
        if (reset) begin
            st[i] = 0; prev[i] = 0; dv[i] = 0; tc[i] = 0; fc[i] = 0;
            jp[i] = 1'b0; fresh[i] = 1'b1;
            return;
        end
        fresh[i] = 1'b0;
        prev[i]  = st[i];
        jok = jump && st[i] != 0 && st[i] != 7;
        ack = plot_done || (tc[i] + 1 >= p_to[i]);
        col = (int'(bird_y) <= p_yt[i]) || (int'(bird_y) >= p_yb[i]) || hit_pipe;
        nx  = st[i];
        if (jok) jp[i] = 1'b1;
        case (st[i])
            0: if (start) nx = 1;
            1: if (frame_tick) begin
                   dv[i] = dv[i] + 1;
                   if (dv[i] == p_fd[i]) begin dv[i] = 0; nx = 2; end
               end
            2: if (ack) nx = 3;
            3: nx = 4;
            4: begin jp[i] = jok; nx = 5; end
            5: if (ack) nx = 6;
            6: if (col) nx = 7;
               else begin fc[i] = (fc[i] + 1) % 256; nx = 1; end
            default: if (start) nx = 0;
        endcase
        tc[i] = (nx == st[i] && (st[i] == 2 || st[i] == 5)) ? tc[i] + 1 : 0;
        st[i] = nx;
    endtask

    always @(posedge clk) begin
        if (reset) model_valid = 1'b1;
        for (int i = 0; i < 2; i++) model_step(i);
    end

    task automatic check_one(int i, logic [2:0] cs, logic li, logic ly, logic lv, logic lj,
                             logic ps, logic pe, logic go, logic [7:0] fcv);
        bit entered;
        entered = (st[i] != prev[i]);
        cmp("cur_state",   i, cs,  st[i]);
        cmp("ld_init",     i, li,  int'(st[i] == 0 && !fresh[i]));
        cmp("ld_y",        i, ly,  int'(st[i] == 3));
        cmp("ld_vy",       i, lv,  int'(st[i] == 4 && !jp[i]));
        cmp("ld_jump",     i, lj,  int'(st[i] == 4 && jp[i]));
        cmp("plot_start",  i, ps,  int'((st[i] == 2 || st[i] == 5) && entered));
        cmp("plot_erase",  i, pe,  int'(st[i] == 2 && entered));
        cmp("game_over",   i, go,  int'(st[i] == 7));
        cmp("frame_count", i, fcv, fc[i]);
    endtask

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (model_valid) begin
            check_one(0, bus0.cur_state, bus0.ld_init, bus0.ld_y, bus0.ld_vy, bus0.ld_jump,
                      bus0.plot_start, bus0.plot_erase, bus0.game_over, bus0.frame_count);
            check_one(1, bus1.cur_state, bus1.ld_init, bus1.ld_y, bus1.ld_vy, bus1.ld_jump,
                      bus1.plot_start, bus1.plot_erase, bus1.game_over, bus1.frame_count);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        jump       = 1'b0;
        plot_done  = 1'b0;
        start      = 1'b0;
    endtask

    logic [7:0] edge_y [10] = '{8'd0, 8'd1, 8'd10, 8'd11, 8'd99, 8'd100, 8'd111, 8'd112, 8'd113, 8'd255};

    initial begin
        reset = 1'b1; frame_tick = 1'b0; jump = 1'b0; start = 1'b0;
        bird_y = 8'd50; hit_pipe = 1'b0; plot_done = 1'b0;
        step(); step();
        reset = 1'b0;
        cmp("lit_reset_state", 0, bus0.cur_state, 0);
        cmp("lit_reset_init",  0, bus0.ld_init, 0);
        cmp("lit_reset_fc",    0, bus0.frame_count, 0);
        step();
        cmp("lit_idle_init", 0, bus0.ld_init, 1);
        start = 1'b1; step();
        cmp("lit_wait", 0, bus0.cur_state, 1);
        frame_tick = 1'b1; step();
        cmp("lit_erase",    0, bus0.cur_state, 2);
        cmp("lit_erase_ps", 0, bus0.plot_start, 1);
        cmp("lit_erase_pe", 0, bus0.plot_erase, 1);
        jump = 1'b1; step();
        cmp("lit_erase_ps1", 0, bus0.plot_start, 0);
        jump = 1'b1; step();
        plot_done = 1'b1; step();
        cmp("lit_upd_y", 0, bus0.ld_y, 1);
        step();
        cmp("lit_jump",    0, bus0.ld_jump, 1);
        cmp("lit_no_vy",   0, bus0.ld_vy, 0);
        step();
        cmp("lit_draw_ps", 0, bus0.plot_start, 1);
        cmp("lit_draw_pe", 0, bus0.plot_erase, 0);
        plot_done = 1'b1; step();
        cmp("lit_check", 0, bus0.cur_state, 6);
        step();
        cmp("lit_back_wait", 0, bus0.cur_state, 1);
        cmp("lit_fc1",       0, bus0.frame_count, 1);
        frame_tick = 1'b1; step();
        plot_done = 1'b1; step();
        step();
        cmp("lit_vy2",   0, bus0.ld_vy, 1);
        cmp("lit_jump2", 0, bus0.ld_jump, 0);
        step();
        plot_done = 1'b1; step();
        bird_y = 8'd112; step();
        bird_y = 8'd50;
        cmp("lit_gameover",    0, bus0.game_over, 1);
        cmp("lit_gameover_fc", 0, bus0.frame_count, 1);
        start = 1'b1; step();
        cmp("lit_reinit", 0, bus0.ld_init, 1);
        cmp("lit_go_low", 0, bus0.game_over, 0);
        start = 1'b1; step();
        frame_tick = 1'b1; step();
        plot_done = 1'b1; step();
        jump = 1'b1; step();
        cmp("lit_jump3", 0, bus0.ld_jump, 1);
        reset = 1'b1; jump = 1'b1; step();
        reset = 1'b0;
        cmp("lit_rst_state", 0, bus0.cur_state, 0);
        cmp("lit_rst_jump",  0, bus0.ld_jump, 0);
        cmp("lit_rst_fc",    0, bus0.frame_count, 0);
        start = 1'b1; step();
        frame_tick = 1'b1; step();
        plot_done = 1'b1; step();
        step();
        cmp("lit_jp_cleared", 0, bus0.ld_vy, 1);

        // frame divider and draw timeout on the second instance
        reset = 1'b1; step();
        reset = 1'b0;
        start = 1'b1; step();
        frame_tick = 1'b1; step();
        cmp("lit_div1", 1, bus1.cur_state, 1);
        frame_tick = 1'b1; step();
        cmp("lit_div2", 1, bus1.cur_state, 1);
        frame_tick = 1'b1; step();
        cmp("lit_div3", 1, bus1.cur_state, 2);
        for (int k = 0; k < 15; k++) begin frame_tick = 1'b1; step(); end
        cmp("lit_erase_hold", 1, bus1.cur_state, 2);
        frame_tick = 1'b1; step();
        cmp("lit_erase_to", 1, bus1.cur_state, 3);
        step(); step();
        cmp("lit_draw1", 1, bus1.cur_state, 5);
        for (int k = 0; k < 15; k++) begin frame_tick = 1'b1; step(); end
        cmp("lit_draw_hold", 1, bus1.cur_state, 5);
        frame_tick = 1'b1; step();
        cmp("lit_draw_to", 1, bus1.cur_state, 6);
        step();
        cmp("lit_div_wait", 1, bus1.cur_state, 1);
        cmp("lit_div_fc",   1, bus1.frame_count, 1);
        frame_tick = 1'b1; step();
        frame_tick = 1'b1; step();
        cmp("lit_drop1", 1, bus1.cur_state, 1);
        frame_tick = 1'b1; step();
        cmp("lit_drop2", 1, bus1.cur_state, 2);

        // randomized play
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 199) == 0);
            start      = ($urandom_range(0, 7) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            jump       = ($urandom_range(0, 5) == 0);
            plot_done  = ($urandom_range(0, 3) == 0);
            hit_pipe   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) < 8) bird_y = 8'($urandom_range(20, 90));
            else bird_y = edge_y[$urandom_range(0, 9)];
            step();
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
